// File: rtl/por_seq_pkg.sv
// por_seq_pkg: shared state encoding, default timing constants and a small
// helper for the POR reset sequencer.
package por_seq_pkg;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_STAGE_DELAY     = 8;

   typedef enum logic [2:0] {
      HOLD       = 3'd0,
      DEBOUNCE   = 3'd1,
      REL_CORE   = 3'd2,
      REL_PERIPH = 3'd3,
      RUN        = 3'd4,
      SOFT       = 3'd5
   } por_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/por_sync.sv
// por_sync: STAGES-deep flop chain that brings an asynchronous level into the
// clk domain. The clear is synchronous and active-low, so a fresh reset always
// forces the synchronized level low.
module por_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_reg;

   // Shift the raw level through the chain; every stage clears on reset.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], d};
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// por_reset_sequencer: synchronizes and debounces the POR level, then releases
// core, peripheral and user resets in that order with STAGE_DELAY spacing.
// Losing porb_l drops every reset at once. The optional soft reset handshake
// (soft_rst_req/soft_rst_ack and the SOFT state) is built when the macro
// POR_SOFT_RESET_EN is defined.
module por_reset_sequencer
   import por_seq_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int STAGE_DELAY     = DEF_STAGE_DELAY
) (
   input  logic clk,
   input  logic resetb,
   input  logic porb_l,
`ifdef POR_SOFT_RESET_EN
   input  logic soft_rst_req,
   output logic soft_rst_ack,
`endif
   output logic core_resetn,
   output logic periph_resetn,
   output logic user_resetn,
   output logic por_done
);

   // Counter is one bit wider than needed so the terminal counts never sit
   // on the saturation value.
   localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, STAGE_DELAY)) + 1;
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_DELAY - 1);

   logic             porb_s;
   por_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             core_reg, periph_reg, user_reg, done_reg;

   por_sync #(
      .STAGES (SYNC_STAGES)
   ) u_porb_sync (
      .clk    (clk),
      .resetb (resetb),
      .d      (porb_l),
      .q      (porb_s)
   );

   // Next-state and counter decode; power loss overrides every other move.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HOLD:       if (porb_s) state_next = DEBOUNCE;
         DEBOUNCE:   if (cnt_reg == DEB_LAST) state_next = REL_CORE;
         REL_CORE:   if (cnt_reg == STG_LAST) state_next = REL_PERIPH;
         REL_PERIPH: if (cnt_reg == STG_LAST) state_next = RUN;
`ifdef POR_SOFT_RESET_EN
         RUN:        if (soft_rst_req) state_next = SOFT;
         SOFT:       if ((cnt_reg >= STG_LAST) && !soft_rst_req) state_next = DEBOUNCE;
`else
         RUN:        state_next = RUN;
`endif
         default:    state_next = HOLD;
      endcase
      if (!porb_s) begin
         state_next = HOLD;
      end

      // Cleared on every state entry, otherwise counts up and saturates.
      if (state_next != state_reg) begin
         cnt_next = '0;
      end else if (cnt_reg == CNT_SAT) begin
         cnt_next = cnt_reg;
      end else begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_reg <= HOLD;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Reset outputs are loaded from the next-state so they move with the state.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         core_reg   <= 1'b0;
         periph_reg <= 1'b0;
         user_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         core_reg   <= (state_next == REL_CORE) || (state_next == REL_PERIPH) ||
                       (state_next == RUN);
         periph_reg <= (state_next == REL_PERIPH) || (state_next == RUN);
         user_reg   <= (state_next == RUN);
         done_reg   <= (state_next == RUN);
      end
   end

   assign core_resetn   = core_reg;
   assign periph_resetn = periph_reg;
   assign user_resetn   = user_reg;
   assign por_done      = done_reg;

`ifdef POR_SOFT_RESET_EN
   logic ack_reg;

   // Acknowledge is held for the whole time the block sits in SOFT.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         ack_reg <= 1'b0;
      end else begin
         ack_reg <= (state_next == SOFT);
      end
   end

   assign soft_rst_ack = ack_reg;
`endif

endmodule

// File: tb/tb_por_reset_sequencer.sv
// tb_por_reset_sequencer: scenario tasks plus a randomized run, all checked
// against a timestamp-based reference model ("how many edges since the
// debounce started"), not a state machine copy.
`timescale 1ns/1ps
module tb_por_reset_sequencer;

   localparam int SYNC       = 2;
   localparam int DEB        = 16;
   localparam int SD         = 8;
   localparam int CORE_AGE   = DEB;
   localparam int PERIPH_AGE = DEB + SD;
   localparam int RUN_AGE    = DEB + 2 * SD;
`ifdef POR_SOFT_RESET_EN
   localparam bit SOFT_EN = 1'b1;
`else
   localparam bit SOFT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetb = 1'b0;
   logic porb_l = 1'b0;
   logic soft_rst_req = 1'b0;
   logic core_resetn, periph_resetn, user_resetn, por_done, soft_rst_ack;

   always #5 clk = ~clk;

   por_reset_sequencer #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .STAGE_DELAY     (SD)
   ) dut (
      .clk           (clk),
      .resetb        (resetb),
      .porb_l        (porb_l),
`ifdef POR_SOFT_RESET_EN
      .soft_rst_req  (soft_rst_req),
      .soft_rst_ack  (soft_rst_ack),
`endif
      .core_resetn   (core_resetn),
      .periph_resetn (periph_resetn),
      .user_resetn   (user_resetn),
      .por_done      (por_done)
   );

`ifndef POR_SOFT_RESET_EN
   assign soft_rst_ack = 1'b0;
`endif

   // Reference model: past porb_l samples, whether a release sequence is in
   // progress, and how many edges have passed since it (or SOFT) began.
   bit         hist[$];
   bit         in_seq, in_soft;
   int         age, soft_age;
   logic [4:0] exp_vec;
   logic [4:0] obs_vec;
   int         checks = 0;
   int         failures = 0;

   assign obs_vec = {core_resetn, periph_resetn, user_resetn, por_done, soft_rst_ack};

   // Advance one clock edge, update the model from the inputs sampled on it,
   // then step 1 ns past the edge so DUT outputs are stable.
   task automatic advance();
      bit ps;
      @(posedge clk);
      if (!resetb) begin
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
         in_seq = 0; in_soft = 0; age = 0; soft_age = 0;
      end else begin
         ps = hist.pop_front();
         hist.push_back(porb_l);
         if (!ps) begin
            in_seq = 0; in_soft = 0;
         end else if (in_soft) begin
            soft_age++;
            if (soft_age >= SD && !soft_rst_req) begin
               in_soft = 0; age = 0;
            end
         end else if (!in_seq) begin
            in_seq = 1; age = 0;
         end else if (SOFT_EN && age >= RUN_AGE && soft_rst_req) begin
            in_soft = 1; soft_age = 0;
         end else if (age < 1000) begin
            age++;
         end
      end
      if (in_soft) exp_vec = 5'b00001;
      else exp_vec = {in_seq && age >= CORE_AGE, in_seq && age >= PERIPH_AGE,
                      in_seq && age >= RUN_AGE, in_seq && age >= RUN_AGE, 1'b0};
      #1;
   endtask

   task automatic test_reset();
      resetb = 1'b0; soft_rst_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         porb_l = 1'($urandom_range(0, 1));
         advance();
         checks++;
         if (obs_vec !== 5'b00000) begin
            failures++;
            $display("FAIL reset_values got=%b want=%b", obs_vec, 5'b00000);
         end
      end
      $display("reset: outputs=%b", obs_vec);
   endtask

   task automatic test_power_up();
      int core_e = 0, periph_e = 0, user_e = 0, done_e = 0;
      resetb = 1'b1; porb_l = 1'b0;
      repeat (3) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL power_up_idle got=%b want=%b", obs_vec, exp_vec);
         end
      end
      porb_l = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL power_up edge=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
         if (core_resetn === 1'b1 && core_e == 0) core_e = k;
         if (periph_resetn === 1'b1 && periph_e == 0) periph_e = k;
         if (user_resetn === 1'b1 && user_e == 0) user_e = k;
         if (por_done === 1'b1 && done_e == 0) done_e = k;
      end
      checks++;
      if (core_e != SYNC + 1 + DEB) begin
         failures++; $display("FAIL core_rise_edge got=%0d want=%0d", core_e, SYNC + 1 + DEB);
      end
      checks++;
      if (periph_e != SYNC + 1 + DEB + SD) begin
         failures++; $display("FAIL periph_rise_edge got=%0d want=%0d", periph_e, SYNC + 1 + DEB + SD);
      end
      checks++;
      if (user_e != SYNC + 1 + DEB + 2 * SD || done_e != SYNC + 1 + DEB + 2 * SD) begin
         failures++;
         $display("FAIL user_done_rise_edge got=%0d/%0d want=%0d", user_e, done_e, SYNC + 1 + DEB + 2 * SD);
      end
      $display("power_up: core@%0d periph@%0d user@%0d done@%0d", core_e, periph_e, user_e, done_e);
   endtask

   task automatic test_glitch();
      int core_e = 0;
      int gpos, glen;
      porb_l = 1'b0;
      repeat (4) advance();
      for (int k = 1; k <= 50; k++) begin
         porb_l = (k == 10) ? 1'b0 : 1'b1;
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL glitch edge=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
         if (core_resetn === 1'b1 && core_e == 0) core_e = k;
      end
      checks++;
      if (core_e != 10 + SYNC + 1 + DEB) begin
         failures++; $display("FAIL glitch_core_edge got=%0d want=%0d", core_e, 10 + SYNC + 1 + DEB);
      end
      $display("glitch: core@%0d after 1-cycle drop at edge 10", core_e);
      for (int it = 0; it < 4; it++) begin
         gpos = $urandom_range(1, 40);
         glen = $urandom_range(1, 3);
         porb_l = 1'b0;
         repeat (3) advance();
         for (int k = 1; k <= 60; k++) begin
            porb_l = (k >= gpos && k < gpos + glen) ? 1'b0 : 1'b1;
            advance();
            checks++;
            if (obs_vec !== exp_vec) begin
               failures++;
               $display("FAIL glitch_rand pos=%0d len=%0d edge=%0d got=%b want=%b", gpos, glen, k, obs_vec, exp_vec);
            end
         end
         $display("glitch_rand: pos=%0d len=%0d outputs=%b", gpos, glen, obs_vec);
      end
   endtask

   task automatic test_brownout();
      porb_l = 1'b1;
      repeat (45) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL brownout_pre got=%b want=%b", obs_vec, exp_vec);
         end
      end
      checks++;
      if (obs_vec !== 5'b11110) begin
         failures++; $display("FAIL brownout_in_run got=%b want=%b", obs_vec, 5'b11110);
      end
      porb_l = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL brownout edge=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
         if (k == SYNC + 1) begin
            checks++;
            if (obs_vec !== 5'b00000) begin
               failures++; $display("FAIL brownout_drop_edge got=%b want=%b", obs_vec, 5'b00000);
            end
         end
      end
      $display("brownout: outputs=%b", obs_vec);
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      int core_e = 0, periph_e = 0, user_e = 0;
      porb_l = 1'b1;
      for (int k = 0; k < 60 && !found; k++) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL reset_mid_pre got=%b want=%b", obs_vec, exp_vec);
         end
         if (exp_vec[3] && !exp_vec[2]) found = 1;
      end
      checks++;
      if (!found) begin
         failures++; $display("FAIL reset_mid_reach_periph got=0 want=1");
      end
      repeat ($urandom_range(0, 5)) advance();
      resetb = 1'b0;
      advance();
      checks++;
      if (obs_vec !== 5'b00000 || obs_vec !== exp_vec) begin
         failures++; $display("FAIL reset_mid_drop got=%b want=%b", obs_vec, 5'b00000);
      end
      resetb = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL reset_mid edge=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
         if (core_resetn === 1'b1 && core_e == 0) core_e = k;
         if (periph_resetn === 1'b1 && periph_e == 0) periph_e = k;
         if (user_resetn === 1'b1 && user_e == 0) user_e = k;
      end
      checks++;
      if (core_e != SYNC + 1 + DEB || periph_e != SYNC + 1 + DEB + SD || user_e != SYNC + 1 + DEB + 2 * SD) begin
         failures++;
         $display("FAIL reset_mid_restart got=%0d/%0d/%0d want=%0d/%0d/%0d", core_e, periph_e, user_e,
                  SYNC + 1 + DEB, SYNC + 1 + DEB + SD, SYNC + 1 + DEB + 2 * SD);
      end
      $display("reset_mid: restart core@%0d periph@%0d user@%0d", core_e, periph_e, user_e);
   endtask

`ifdef POR_SOFT_RESET_EN
   task automatic test_soft_reset();
      int core_e = 0, periph_e = 0, user_e = 0;
      porb_l = 1'b1; soft_rst_req = 1'b0;
      repeat (45) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL soft_pre got=%b want=%b", obs_vec, exp_vec);
         end
      end
      soft_rst_req = 1'b1;
      advance();
      checks++;
      if (obs_vec !== 5'b00001 || obs_vec !== exp_vec) begin
         failures++; $display("FAIL soft_entry got=%b want=%b", obs_vec, 5'b00001);
      end
      for (int k = 1; k <= 48; k++) begin
         if (k == 4) soft_rst_req = 1'b0;
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL soft edge=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
         if (core_resetn === 1'b1 && core_e == 0) core_e = k;
         if (periph_resetn === 1'b1 && periph_e == 0) periph_e = k;
         if (user_resetn === 1'b1 && user_e == 0) user_e = k;
      end
      checks++;
      if (core_e != DEB + ((SD > 4) ? SD : 4) || periph_e != core_e + SD || user_e != core_e + 2 * SD) begin
         failures++;
         $display("FAIL soft_release got=%0d/%0d/%0d want=%0d/+%0d/+%0d", core_e, periph_e, user_e,
                  DEB + ((SD > 4) ? SD : 4), SD, 2 * SD);
      end
      $display("soft_reset: core@%0d periph@%0d user@%0d after entry", core_e, periph_e, user_e);
   endtask

   task automatic test_soft_outside_run();
      int user_e = 0, ack_e = 0;
      porb_l = 1'b0;
      repeat (4) advance();
      porb_l = 1'b1; soft_rst_req = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL soft_early edge=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
         if (user_resetn === 1'b1 && user_e == 0) user_e = k;
         if (soft_rst_ack === 1'b1 && ack_e == 0) ack_e = k;
      end
      checks++;
      if (user_e != SYNC + 1 + RUN_AGE || ack_e != SYNC + 2 + RUN_AGE) begin
         failures++;
         $display("FAIL soft_early_timing got=%0d/%0d want=%0d/%0d", user_e, ack_e, SYNC + 1 + RUN_AGE, SYNC + 2 + RUN_AGE);
      end
      soft_rst_req = 1'b0;
      repeat (45) begin
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL soft_early_exit got=%b want=%b", obs_vec, exp_vec);
         end
      end
      $display("soft_outside_run: user@%0d ack@%0d", user_e, ack_e);
   endtask
`endif

   task automatic test_random();
      resetb = 1'b1; porb_l = 1'b1; soft_rst_req = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 49) == 0) porb_l = ~porb_l;
         resetb = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         if (SOFT_EN && $urandom_range(0, 29) == 0) soft_rst_req = ~soft_rst_req;
         advance();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++; $display("FAIL random cycle=%0d got=%b want=%b", k, obs_vec, exp_vec);
         end
      end
      resetb = 1'b1;
      $display("random: 1500 cycles, last outputs=%b", obs_vec);
   endtask

   initial begin
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      test_reset();
      test_power_up();
      test_glitch();
      test_brownout();
      test_reset_mid();
`ifdef POR_SOFT_RESET_EN
      test_soft_reset();
      test_soft_outside_run();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
